mem_wb_stage_ws: RTL and testbench

Parametrised successor to the combined Mem/WB stage. It adds a configurable wait-state data memory, a stall handshake back to EX, a registered WB output bundle with destination register, and out-of-range address detection. It sits between EX and the register file. Non-memory ops still complete in one cycle; loads and stores take 1+WAIT_STATES cycles.

---
 rtl/mem_wb_stage_ws.sv | 151 +++++++++++++++
 tb/tb_mem_wb_stage_ws.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_ws.sv
// Mem/WB stage with wait-state data memory, EX stall handshake
// and registered write-back bundle with out-of-range flag.
module mem_wb_stage_ws #(
  parameter int DSIZE       = 16,
  parameter int ASIZE       = 8,
  parameter int RSIZE       = 3,
  parameter int WAIT_STATES = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ex_valid,
  input  logic [DSIZE-1:0] ex_aluResult,
  input  logic [DSIZE-1:0] ex_storeData,
  input  logic             ex_memRead,
  input  logic             ex_memWrite,
  input  logic             ex_mem2reg,
  input  logic             ex_regWrite,
  input  logic [RSIZE-1:0] ex_wrAddr,
  output logic             stall,
  output logic             wb_valid,
  output logic             wb_regWrite,
  output logic [RSIZE-1:0] wb_wrAddr,
  output logic [DSIZE-1:0] wb_writeData,
  output logic             wb_err_oob
);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [DSIZE-1:0] alu;
    logic [DSIZE-1:0] sd;
    logic             re;
    logic             we;
    logic             m2r;
    logic             rw;
    logic             oob;
    logic [RSIZE-1:0] wa;
  } op_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  logic [DSIZE-1:0] mem [2**ASIZE];

  state_t           state;
  logic [2:0]       cnt;
  op_t              cap;
  op_t              inc;
  op_t              cur;
  logic             oob;
  logic             accept;
  logic             is_mem;
  logic             fast;
  logic             commit;
  logic             mem_we;
  logic [ASIZE-1:0] addr;
  logic [DSIZE-1:0] rdata;
  logic [DSIZE-1:0] wdata;

  logic             pend_v;
  logic             pend_rw;
  logic             pend_oob;
  logic [RSIZE-1:0] pend_wa;
  logic [DSIZE-1:0] pend_d;

  if (DSIZE > ASIZE) begin : g_oob
    assign oob = |ex_aluResult[DSIZE-1:ASIZE];
  end else begin : g_no_oob
    assign oob = 1'b0;
  end

  always_comb begin
    inc     = '0;
    inc.alu = ex_aluResult;
    inc.sd  = ex_storeData;
    inc.we  = ex_memWrite;
    inc.re  = ex_memRead & ~ex_memWrite;
    inc.m2r = ex_mem2reg & ~(ex_memRead & ex_memWrite);
    inc.rw  = ex_regWrite;
    inc.oob = oob;
    inc.wa  = ex_wrAddr;
  end

  assign accept = ex_valid & ~stall;
  assign is_mem = inc.re | inc.we;
  assign fast   = accept & (~is_mem | (WS == 3'd0));
  assign commit = (state == BUSY) & (cnt == 3'd1);

  // zero-wait ops access memory straight from EX; others from the capture
  assign cur    = commit ? cap : inc;
  assign addr   = ASIZE'(cur.alu);
  assign rdata  = (cur.re & ~cur.oob) ? mem[addr] : '0;
  assign wdata  = (cur.re & cur.m2r) ? rdata : cur.alu;
  assign mem_we = ~Rst & (fast | commit) & cur.we & ~cur.oob;

  always_ff @(posedge Clk) begin
    if (mem_we) mem[addr] <= cur.sd;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      stall        <= 1'b0;
      cap          <= '0;
      pend_v       <= 1'b0;
      pend_rw      <= 1'b0;
      pend_oob     <= 1'b0;
      pend_wa      <= '0;
      pend_d       <= '0;
      wb_valid     <= 1'b0;
      wb_regWrite  <= 1'b0;
      wb_err_oob   <= 1'b0;
      wb_wrAddr    <= '0;
      wb_writeData <= '0;
    end else begin
      pend_v <= fast | commit;
      if (fast | commit) begin
        pend_d   <= wdata;
        pend_rw  <= cur.rw & ~(cur.we & cur.m2r);
        pend_oob <= cur.oob & (cur.re | cur.we);
        pend_wa  <= cur.wa;
      end
      wb_valid    <= pend_v;
      wb_regWrite <= pend_v & pend_rw;
      wb_err_oob  <= pend_v & pend_oob;
      if (pend_v) begin
        wb_wrAddr    <= pend_wa;
        wb_writeData <= pend_d;
      end
      unique case (state)
        IDLE: begin
          if (accept) cap <= inc;
          if (accept & is_mem & (WS != 3'd0)) begin
            state <= BUSY;
            cnt   <= WS;
            stall <= 1'b1;
          end
        end
        BUSY: begin
          cnt <= cnt - 3'd1;
          if (commit) begin
            state <= IDLE;
            stall <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage_ws.sv
// Directed bench for mem_wb_stage_ws: a WAIT_STATES=2 instance
// and a WAIT_STATES=0 instance share the EX-side stimulus.
module tb_mem_wb_stage_ws;

  logic        Clk;
  logic        Rst;
  logic        ex_valid;
  logic [15:0] ex_aluResult;
  logic [15:0] ex_storeData;
  logic        ex_memRead;
  logic        ex_memWrite;
  logic        ex_mem2reg;
  logic        ex_regWrite;
  logic [2:0]  ex_wrAddr;

  logic        s2, v2, r2, e2;
  logic [2:0]  a2;
  logic [15:0] d2;
  logic        s0, v0, r0, e0;
  logic [2:0]  a0;
  logic [15:0] d0;

  int checks = 0;
  int failures = 0;

  mem_wb_stage_ws #(.DSIZE(16), .ASIZE(8), .RSIZE(3), .WAIT_STATES(2)) u_ws2 (
    .Clk(Clk), .Rst(Rst), .ex_valid(ex_valid),
    .ex_aluResult(ex_aluResult), .ex_storeData(ex_storeData),
    .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_mem2reg(ex_mem2reg), .ex_regWrite(ex_regWrite),
    .ex_wrAddr(ex_wrAddr), .stall(s2), .wb_valid(v2),
    .wb_regWrite(r2), .wb_wrAddr(a2), .wb_writeData(d2),
    .wb_err_oob(e2)
  );

  mem_wb_stage_ws #(.DSIZE(16), .ASIZE(8), .RSIZE(3), .WAIT_STATES(0)) u_ws0 (
    .Clk(Clk), .Rst(Rst), .ex_valid(ex_valid),
    .ex_aluResult(ex_aluResult), .ex_storeData(ex_storeData),
    .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_mem2reg(ex_mem2reg), .ex_regWrite(ex_regWrite),
    .ex_wrAddr(ex_wrAddr), .stall(s0), .wb_valid(v0),
    .wb_regWrite(r0), .wb_wrAddr(a0), .wb_writeData(d0),
    .wb_err_oob(e0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] alu, input logic [15:0] sd,
                       input logic mr, input logic mw, input logic m2r,
                       input logic rw, input logic [2:0] wa);
    ex_aluResult = alu;
    ex_storeData = sd;
    ex_memRead   = mr;
    ex_memWrite  = mw;
    ex_mem2reg   = m2r;
    ex_regWrite  = rw;
    ex_wrAddr    = wa;
  endtask

  task automatic run_op(input bit sel, input logic [15:0] alu,
                        input logic [15:0] sd, input logic mr,
                        input logic mw, input logic m2r, input logic rw,
                        input logic [2:0] wa, output int lat,
                        output int stl, output logic [15:0] wd,
                        output logic rwo, output logic [2:0] wao,
                        output logic err);
    drive(alu, sd, mr, mw, m2r, rw, wa);
    ex_valid = 1'b1;
    step();
    ex_valid = 1'b0;
    lat = -1;
    wd  = '0;
    rwo = 1'b0;
    wao = '0;
    err = 1'b0;
    stl = int'(sel ? s0 : s2);
    for (int i = 1; i <= 12; i++) begin
      step();
      if (sel ? v0 : v2) begin
        lat = i;
        wd  = sel ? d0 : d2;
        rwo = sel ? r0 : r2;
        wao = sel ? a0 : a2;
        err = sel ? e0 : e2;
        break;
      end
      stl += int'(sel ? s0 : s2);
    end
  endtask

  int          lat, stl, cnt;
  logic [15:0] wd;
  logic        rw, er;
  logic [2:0]  wa;

  logic [15:0] t6_alu [4] = '{16'h0030, 16'h0030, 16'h0031, 16'h0031};
  logic [15:0] t6_sd  [4] = '{16'hA001, 16'h0000, 16'hA002, 16'h0000};
  logic        t6_ld  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [2:0]  t6_wa  [4] = '{3'd0, 3'd1, 3'd0, 3'd2};
  logic [15:0] t6_exp [4] = '{16'h0030, 16'hA001, 16'h0031, 16'hA002};

  initial begin
    Rst = 1'b1;
    ex_valid = 1'b0;
    drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
    step();
    chk("rst_stall", s2, 0);
    chk("rst_valid", v2, 0);
    chk("rst_data", d2, 0);
    chk("rst_regwrite", r2, 0);
    chk("rst0_valid", v0, 0);
    Rst = 1'b0;

    run_op(0, 16'h1234, 16'h0, 0, 0, 0, 1, 3'd5, lat, stl, wd, rw, wa, er);
    chk("alu_lat", lat, 1);
    chk("alu_stall", stl, 0);
    chk("alu_data", wd, 16'h1234);
    chk("alu_rw", rw, 1);
    chk("alu_wa", wa, 5);
    chk("alu_err", er, 0);
    step();
    chk("alu_pulse", v2, 0);
    chk("alu_rw_clr", r2, 0);
    chk("alu_hold", d2, 16'h1234);

    run_op(0, 16'h0010, 16'hBEEF, 0, 1, 0, 0, 3'd0, lat, stl, wd, rw, wa, er);
    chk("st_lat", lat, 3);
    chk("st_stall", stl, 2);
    chk("st_rw", rw, 0);
    chk("st_err", er, 0);
    run_op(0, 16'h0010, 16'h0, 1, 0, 1, 1, 3'd3, lat, stl, wd, rw, wa, er);
    chk("ld_lat", lat, 3);
    chk("ld_stall", stl, 2);
    chk("ld_data", wd, 16'hBEEF);
    chk("ld_rw", rw, 1);
    chk("ld_wa", wa, 3);

    run_op(0, 16'h0110, 16'h5555, 0, 1, 0, 0, 3'd0, lat, stl, wd, rw, wa, er);
    chk("oob_st_lat", lat, 3);
    chk("oob_st_err", er, 1);
    run_op(0, 16'h0010, 16'h0, 1, 0, 1, 1, 3'd1, lat, stl, wd, rw, wa, er);
    chk("oob_keep", wd, 16'hBEEF);
    chk("oob_keep_err", er, 0);
    run_op(0, 16'h0110, 16'h0, 1, 0, 1, 1, 3'd4, lat, stl, wd, rw, wa, er);
    chk("oob_ld_lat", lat, 3);
    chk("oob_ld_data", wd, 0);
    chk("oob_ld_err", er, 1);

    drive(16'h0010, 16'h0, 1, 0, 1, 1, 3'd6);
    ex_valid = 1'b1;
    step();
    drive(16'h0020, 16'h0, 1, 0, 0, 1, 3'd2);
    step();
    chk("hold_v1", v2, 0);
    step();
    chk("hold_s2", s2, 0);
    chk("hold_v2", v2, 0);
    step();
    ex_valid = 1'b0;
    chk("hold_va", v2, 1);
    chk("hold_da", d2, 16'hBEEF);
    chk("hold_wa", a2, 6);
    chk("hold_acc", s2, 1);
    step();
    chk("hold_v4", v2, 0);
    step();
    chk("hold_v5", v2, 0);
    step();
    chk("hold_vb", v2, 1);
    chk("hold_db", d2, 16'h0020);
    chk("hold_wb", a2, 2);

    run_op(0, 16'h0020, 16'h1111, 0, 1, 0, 0, 3'd0, lat, stl, wd, rw, wa, er);
    chk("pre_st_lat", lat, 3);
    drive(16'h0020, 16'h2222, 0, 1, 0, 0, 3'd0);
    ex_valid = 1'b1;
    step();
    ex_valid = 1'b0;
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk("abort_stall", s2, 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      cnt += int'(v2);
    end
    chk("abort_novalid", cnt, 0);
    run_op(0, 16'h0020, 16'h0, 1, 0, 1, 1, 3'd7, lat, stl, wd, rw, wa, er);
    chk("abort_mem", wd, 16'h1111);

    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        drive(t6_alu[i], t6_sd[i], t6_ld[i], ~t6_ld[i], t6_ld[i],
              t6_ld[i], t6_wa[i]);
        ex_valid = 1'b1;
      end else begin
        ex_valid = 1'b0;
      end
      step();
      chk($sformatf("ws0_stall%0d", i), s0, 0);
      if (i > 0) begin
        chk($sformatf("ws0_v%0d", i), v0, 1);
        chk($sformatf("ws0_d%0d", i), d0, t6_exp[i-1]);
        chk($sformatf("ws0_rw%0d", i), r0, t6_ld[i-1]);
      end
    end
    step();
    chk("ws0_idle", v0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
